// File: rtl/median_uart_tx.sv
// rtl/median_uart_tx.sv - UART transmitter for the triangle-median result frame
//
// Sends HEADER, ad_distance, be_distance, cf_distance (and, when the macro
// MEDIAN_TX_CHECKSUM_EN is defined, a mod-256 sum of the three distances)
// as back-to-back 8N1 bytes, LSB first, idle high.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (must be >= 2)
//   HEADER        frame start byte
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle request to send a frame (ignored while busy)
//   ad_distance  median A->D, captured when start is accepted
//   be_distance  median B->E, captured when start is accepted
//   cf_distance  median C->F, captured when start is accepted
//   tx           serial output, idle high
//   busy         high while a frame is on the line
//   done         one-cycle pulse after the last stop bit
// Configuration macro: MEDIAN_TX_CHECKSUM_EN (appends checksum byte)

module median_uart_tx #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] ad_distance,
    input  logic [7:0] be_distance,
    input  logic [7:0] cf_distance,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    // The stop bit hands its final cycle to NEXT_BYTE, so STOP_BIT itself
    // leaves one cycle early and the line sees exactly one full stop bit.
    localparam logic [CNT_W-1:0] CNT_STOP_END = CNT_W'(CLKS_PER_BIT - 2);

`ifdef MEDIAN_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        NEXT_BYTE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       r_byte_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_ad;
    logic [7:0]       r_be;
    logic [7:0]       r_cf;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       w_next_byte;

`ifdef MEDIAN_TX_CHECKSUM_EN
    logic [7:0]       w_checksum;
    assign w_checksum = r_ad + r_be + r_cf;
`endif

    // Byte that follows the one currently indexed by r_byte_idx.
    always_comb begin
        w_next_byte = 8'h00;
        case (r_byte_idx)
            3'd0:    w_next_byte = r_ad;
            3'd1:    w_next_byte = r_be;
            3'd2:    w_next_byte = r_cf;
`ifdef MEDIAN_TX_CHECKSUM_EN
            3'd3:    w_next_byte = w_checksum;
`endif
            default: w_next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_shift    <= 8'h00;
            r_ad       <= 8'h00;
            r_be       <= 8'h00;
            r_cf       <= 8'h00;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (start) begin
                        r_ad       <= ad_distance;
                        r_be       <= be_distance;
                        r_cf       <= cf_distance;
                        r_shift    <= HEADER;
                        r_byte_idx <= 3'd0;
                        r_clk_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START_BIT;
                    end
                end

                START_BIT: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA_BITS;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                DATA_BITS: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP_BIT;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                STOP_BIT: begin
                    r_clk_cnt <= r_clk_cnt + 1'b1;
                    if (r_clk_cnt == CNT_STOP_END) begin
                        r_state <= NEXT_BYTE;
                    end
                end

                NEXT_BYTE: begin
                    // Final cycle of the stop bit; the next start bit (or the
                    // done pulse) begins on the following edge with no gap.
                    r_clk_cnt <= '0;
                    if (r_byte_idx == LAST_BYTE) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_byte_idx <= r_byte_idx + 3'd1;
                        r_shift    <= w_next_byte;
                        r_tx       <= 1'b0;
                        r_state    <= START_BIT;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_median_uart_tx.sv
// tb/tb_median_uart_tx.sv - self-checking bench for median_uart_tx

module tb_median_uart_tx;

    localparam int CPB = 4;
`ifdef MEDIAN_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int FRAME = NB * 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] ad = 8'h00;
    logic [7:0] be = 8'h00;
    logic [7:0] cf = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    median_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ad_distance(ad), .be_distance(be), .cf_distance(cf),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: a frame is a list of bytes; output at cycle k after
    // acceptance is looked up from byte/bit position by plain arithmetic.
    bit         m_active = 0;
    int         m_k = 0;
    logic [7:0] m_bytes [5];

    function automatic logic exp_tx();
        int pos, b, j;
        if (!m_active || m_k > FRAME) return 1'b1;
        pos = m_k - 1;
        b   = pos / (10 * CPB);
        j   = (pos % (10 * CPB)) / CPB;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return m_bytes[b][j-1];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0;
            m_k = 0;
        end else begin
            if (start && !(m_active && m_k <= FRAME)) begin
                m_bytes[0] = 8'hA5;
                m_bytes[1] = ad;
                m_bytes[2] = be;
                m_bytes[3] = cf;
                m_bytes[4] = 8'((int'(ad) + int'(be) + int'(cf)) % 256);
                m_active = 1;
                m_k = 1;
            end else if (m_active) begin
                m_k++;
                if (m_k > FRAME + 1) m_active = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("tx_cycle",   tx,   exp_tx());
        chk("busy_cycle", busy, (m_active && m_k <= FRAME) ? 1'b1 : 1'b0);
        chk("done_cycle", done, (m_active && m_k == FRAME + 1) ? 1'b1 : 1'b0);
    end

    // Independent line decoder and activity counters.
    logic [7:0] rx_q[$];
    bit         rx_on = 0;
    int         rx_c = 0;
    logic [7:0] rx_sh = 8'h00;
    int         stop_bad = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (rst) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (tx == 1'b0) begin
                rx_on = 1;
                rx_c = 0;
            end
        end else begin
            rx_c++;
            if (rx_c % CPB == CPB / 2 && rx_c / CPB >= 1 && rx_c / CPB <= 8)
                rx_sh[rx_c / CPB - 1] = tx;
            if (rx_c == 9 * CPB + CPB / 2) begin
                if (tx !== 1'b1) stop_bad++;
                rx_q.push_back(rx_sh);
                rx_on = 0;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(posedge clk); #1;
        ad = a; be = b; cf = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < bound) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk(name, done, 1'b1);
    endtask

    task automatic chk_frame(input string name, input int base, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        chk({name, "_hdr"}, rx_q[base],   8'hA5);
        chk({name, "_ad"},  rx_q[base+1], e1);
        chk({name, "_be"},  rx_q[base+2], e2);
        chk({name, "_cf"},  rx_q[base+3], e3);
`ifdef MEDIAN_TX_CHECKSUM_EN
        chk({name, "_sum"}, rx_q[base+4], e4);
`else
        if (e4 == 8'hxx) $display("unused");
`endif
    endtask

    int b0, d0, q0, s0, cyc;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        // Idle 100 cycles
        b0 = busy_cnt; d0 = done_cnt;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_busy_cnt", busy_cnt - b0, 0);
        chk("idle_done_cnt", done_cnt - d0, 0);

        // Basic frame 5,7,9
        b0 = busy_cnt; d0 = done_cnt; q0 = rx_q.size(); s0 = stop_bad;
        send(8'd5, 8'd7, 8'd9);
        chk("first_start_bit", tx, 1'b0);
        chk("first_busy", busy, 1'b1);
        wait_done("basic_done_timeout", 400, cyc);
        chk("basic_done_latency", cyc, FRAME);
        repeat (5) @(posedge clk);
        #1;
        chk("basic_busy_cnt", busy_cnt - b0, FRAME);
        chk("basic_done_cnt", done_cnt - d0, 1);
        chk("basic_nbytes", rx_q.size() - q0, NB);
        chk_frame("basic", q0, 8'h05, 8'h07, 8'h09, 8'h15);

        // Start ignored while busy, inputs changed mid-frame
        b0 = busy_cnt; d0 = done_cnt; q0 = rx_q.size();
        send(8'h11, 8'h22, 8'h33);
        repeat (48) @(posedge clk);
        #1;
        start = 1'b1; ad = 8'hFF; be = 8'hFF; cf = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_done_timeout", 400, cyc);
        repeat (60) @(posedge clk);
        #1;
        chk("busy_busy_cnt", busy_cnt - b0, FRAME);
        chk("busy_done_cnt", done_cnt - d0, 1);
        chk("busy_nbytes", rx_q.size() - q0, NB);
        chk_frame("busy", q0, 8'h11, 8'h22, 8'h33, 8'h66);

        // Reset mid-frame
        d0 = done_cnt;
        send(8'h44, 8'h55, 8'h66);
        repeat (68) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        q0 = rx_q.size();
        send(8'd1, 8'd2, 8'd3);
        wait_done("fresh_done_timeout", 400, cyc);
        repeat (3) @(posedge clk);
        #1;
        chk("fresh_nbytes", rx_q.size() - q0, NB);
        chk_frame("fresh", q0, 8'h01, 8'h02, 8'h03, 8'h06);

        // Back-to-back frames: start in the done cycle
        q0 = rx_q.size(); d0 = done_cnt;
        send(8'd10, 8'd20, 8'd30);
        wait_done("b2b_done1_timeout", 400, cyc);
        ad = 8'h80; be = 8'h80; cf = 8'h80; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_start_bit", tx, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        wait_done("b2b_done2_timeout", 400, cyc);
        chk("b2b_done2_latency", cyc, FRAME);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_done_cnt", done_cnt - d0, 2);
        chk("b2b_nbytes", rx_q.size() - q0, 2 * NB);
        chk_frame("b2b1", q0, 8'h0A, 8'h14, 8'h1E, 8'h3C);
        chk_frame("b2b2", q0 + NB, 8'h80, 8'h80, 8'h80, 8'h80);
        chk("stop_bits", stop_bad - s0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
